// File: rtl/ysyx_22041071_axi_w_arb_if.sv
// Request/beat/response bundle between the write arbiter and the single AXI write-channel master.
// The arbiter takes the master modport; the write master engine takes the slave modport.
interface ysyx_22041071_axi_w_arb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
);
    logic              m_valid;
    logic              m_ready;
    logic [3:0]        m_id;
    logic [ADDR_W-1:0] m_addr;
    logic [LEN_W-1:0]  m_len;
    logic [1:0]        m_size;
    logic [DATA_W-1:0] m_data;
    logic              m_beat;
    logic              m_bvalid;
    logic [1:0]        m_resp;

    modport master (
        output m_valid, m_id, m_addr, m_len, m_size, m_data,
        input  m_ready, m_beat, m_bvalid, m_resp
    );

    modport slave (
        input  m_valid, m_id, m_addr, m_len, m_size, m_data,
        output m_ready, m_beat, m_bvalid, m_resp
    );
endinterface

// File: rtl/ysyx_22041071_axi_w_arb.sv
// Grants the AXI write master to the dcache writeback port (0) or the MMIO store port (1) for a
// whole AW/W/B transaction. Define YSYX_22041071_AXI_W_ARB_FIXED_PRIO_EN for fixed MMIO priority.
module ysyx_22041071_axi_w_arb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8,
    parameter logic [3:0]  ID0    = 4'd1,
    parameter logic [3:0]  ID1    = 4'd2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                rq_valid,
    output logic [1:0]                rq_ready,
    input  logic [ADDR_W-1:0]         rq0_addr,
    input  logic [ADDR_W-1:0]         rq1_addr,
    input  logic [LEN_W-1:0]          rq0_len,
    input  logic [LEN_W-1:0]          rq1_len,
    input  logic [1:0]                rq0_size,
    input  logic [1:0]                rq1_size,
    input  logic [DATA_W-1:0]         rq0_data,
    input  logic [DATA_W-1:0]         rq1_data,
    output logic [1:0]                rq_beat,
    output logic [1:0]                rq_done,
    output logic [1:0][1:0]           rq_resp,
    ysyx_22041071_axi_w_arb_if.master m,
    output logic                      busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StData, StResp} state_e;

    state_e            state_q, state_d;
    logic              own_q, own_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [3:0]        id_q, id_d;
    logic [1:0][1:0]   resp_q, resp_d;
    logic              grant;

    // MMIO stores are always single beat, so its len input is ignored.
    logic unused_rq1_len;
    assign unused_rq1_len = ^rq1_len;

`ifdef YSYX_22041071_AXI_W_ARB_FIXED_PRIO_EN
    assign grant = rq_valid[1];
`else
    logic last_q, last_d;

    // Round-robin at transaction granularity: on contention, serve whoever did not finish last.
    assign grant  = (&rq_valid) ? ~last_q : rq_valid[1];
    assign last_d = (state_q == StResp && m.m_bvalid) ? own_q : last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        beat_d     = beat_q;
        len_d      = len_q;
        addr_d     = addr_q;
        size_d     = size_q;
        id_d       = id_q;
        resp_d     = resp_q;
        rq_ready   = 2'b00;
        rq_beat    = 2'b00;
        rq_done    = 2'b00;
        m.m_valid  = 1'b0;
        m.m_data   = '0;

        unique case (state_q)
            StIdle: begin
                if (|rq_valid) begin
                    state_d = StIssue;
                    own_d   = grant;
                    addr_d  = grant ? rq1_addr : rq0_addr;
                    len_d   = grant ? '0 : rq0_len;
                    size_d  = grant ? rq1_size : rq0_size;
                    id_d    = grant ? ID1 : ID0;
                end
            end
            StIssue: begin
                m.m_valid = 1'b1;
                if (m.m_ready) begin
                    rq_ready[own_q] = 1'b1;
                    beat_d          = '0;
                    state_d         = StData;
                end
            end
            StData: begin
                m.m_data = own_q ? rq1_data : rq0_data;
                if (m.m_beat) begin
                    rq_beat[own_q] = 1'b1;
                    if (beat_q == len_q) begin
                        state_d = StResp;
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            StResp: begin
                if (m.m_bvalid) begin
                    rq_done[own_q] = 1'b1;
                    resp_d[own_q]  = m.m_resp;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Response is visible in the completion cycle and held afterwards.
        rq_resp = resp_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            own_q   <= 1'b0;
            beat_q  <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            id_q    <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            id_q    <= id_d;
            resp_q  <= resp_d;
        end
    end

    assign m.m_id   = id_q;
    assign m.m_addr = addr_q;
    assign m.m_len  = len_q;
    assign m.m_size = size_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ysyx_22041071_axi_w_arb.sv
// Directed bench for the AXI write arbiter: expected requests, beats and completions are queued
// when stimulus is set up and popped as the arbiter produces them.
`timescale 1ns/1ps
module tb_ysyx_22041071_axi_w_arb;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned LEN_W  = 8;
    localparam logic [3:0]  ID0    = 4'd1;
    localparam logic [3:0]  ID1    = 4'd2;
    localparam logic [63:0] D0     = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] D1     = 64'h5A5A_0000_0000_0000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      rq_valid, rq_ready, rq_beat, rq_done;
    logic [1:0][1:0] rq_resp;
    logic [31:0]     rq0_addr, rq1_addr;
    logic [7:0]      rq0_len, rq1_len;
    logic [1:0]      rq0_size, rq1_size;
    logic [63:0]     rq0_data, rq1_data;
    logic            busy;

    ysyx_22041071_axi_w_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) mif ();

    ysyx_22041071_axi_w_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID0(ID0), .ID1(ID1)
    ) dut (
        .clk(clk), .reset(reset),
        .rq_valid(rq_valid), .rq_ready(rq_ready),
        .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
        .rq0_len(rq0_len), .rq1_len(rq1_len),
        .rq0_size(rq0_size), .rq1_size(rq1_size),
        .rq0_data(rq0_data), .rq1_data(rq1_data),
        .rq_beat(rq_beat), .rq_done(rq_done), .rq_resp(rq_resp),
        .m(mif), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  oh;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  size;
    } req_t;
    typedef struct packed {
        logic [1:0]  oh;
        logic [63:0] data;
    } beat_t;
    typedef struct packed {
        logic       who;
        logic [1:0] resp;
    } done_t;

    req_t  req_q[$];
    beat_t beat_q[$];
    done_t done_q[$];

    int checks = 0;
    int errors = 0;
    int idx0 = 0, idx1 = 0, exp0 = 0, exp1 = 0;
    int nbeats = 0;
    logic       acc_seen, done_seen;
    logic [1:0] beat_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_txn(input logic who, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] size, input logic [1:0] resp);
        req_t r;
        beat_t b;
        done_t d;
        r.oh   = who ? 2'b10 : 2'b01;
        r.id   = who ? ID1 : ID0;
        r.addr = addr;
        r.len  = who ? 8'd0 : len;
        r.size = size;
        req_q.push_back(r);
        for (int i = 0; i <= int'(r.len); i++) begin
            b.oh = r.oh;
            if (who) begin
                b.data = D1 + 64'(exp1);
                exp1++;
            end else begin
                b.data = D0 + 64'(exp0);
                exp0++;
            end
            beat_q.push_back(b);
        end
        d.who  = who;
        d.resp = resp;
        done_q.push_back(d);
    endtask

    task automatic monitor();
        req_t r;
        beat_t b;
        done_t d;
        beat_seen = 2'b00;
        if (mif.m_valid && mif.m_ready) begin
            acc_seen = 1'b1;
            chk("req_expected", 64'(req_q.size() > 0), 64'(1));
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                chk("rq_ready", 64'(rq_ready), 64'(r.oh));
                chk("m_id", 64'(mif.m_id), 64'(r.id));
                chk("m_addr", 64'(mif.m_addr), 64'(r.addr));
                chk("m_len", 64'(mif.m_len), 64'(r.len));
                chk("m_size", 64'(mif.m_size), 64'(r.size));
            end
        end else begin
            chk("rq_ready_quiet", 64'(rq_ready), 64'(0));
        end
        if (rq_beat != 2'b00) begin
            beat_seen = rq_beat;
            nbeats++;
            chk("beat_expected", 64'(beat_q.size() > 0), 64'(1));
            if (beat_q.size() > 0) begin
                b = beat_q.pop_front();
                chk("rq_beat", 64'(rq_beat), 64'(b.oh));
                chk("m_data", mif.m_data, b.data);
            end
        end
        if (rq_done != 2'b00) begin
            done_seen = 1'b1;
            chk("done_expected", 64'(done_q.size() > 0), 64'(1));
            if (done_q.size() > 0) begin
                d = done_q.pop_front();
                chk("rq_done", 64'(rq_done), d.who ? 64'(2) : 64'(1));
                chk("rq_resp", 64'(rq_resp[d.who]), 64'(d.resp));
            end
        end
    endtask

    // Sample at the falling edge, then let the requesters advance data after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (beat_seen[0]) begin
            idx0++;
            rq0_data = D0 + 64'(idx0);
        end
        if (beat_seen[1]) begin
            idx1++;
            rq1_data = D1 + 64'(idx1);
        end
    endtask

    task automatic serve(input int nb, input logic gapped, input logic stray, input logic drop,
                         input logic [1:0] resp);
        int t;
        int start;
        mif.m_ready = 1'b1;
        acc_seen = 1'b0;
        t = 0;
        while (!acc_seen && t < 20) begin
            step();
            t++;
        end
        chk("accept_timeout", 64'(acc_seen), 64'(1));
        mif.m_ready = 1'b0;
        if (drop) rq_valid = 2'b00;
        start = nbeats;
        t = 0;
        while (nbeats - start < nb && t < 600) begin
            mif.m_beat = gapped ? (t % 3 == 0) : 1'b1;
            step();
            t++;
        end
        mif.m_beat = 1'b0;
        chk("beat_count", 64'(nbeats - start), 64'(nb));
        chk("busy_in_resp", 64'(busy), 64'(1));
        if (stray) begin
            mif.m_beat = 1'b1;
            step();
            mif.m_beat = 1'b0;
        end
        mif.m_bvalid = 1'b1;
        mif.m_resp = resp;
        done_seen = 1'b0;
        step();
        chk("done_seen", 64'(done_seen), 64'(1));
        mif.m_bvalid = 1'b0;
        mif.m_resp = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        rq_valid = 2'b00;
        rq0_addr = '0; rq1_addr = '0;
        rq0_len = '0;  rq1_len = '0;
        rq0_size = '0; rq1_size = '0;
        rq0_data = D0; rq1_data = D1;
        mif.m_ready = 1'b0; mif.m_beat = 1'b0; mif.m_bvalid = 1'b0; mif.m_resp = 2'b00;
        acc_seen = 1'b0; done_seen = 1'b0; beat_seen = 2'b00;

        // Reset values.
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_valid", 64'(mif.m_valid), 64'(0));
        chk("rst_rq_ready", 64'(rq_ready), 64'(0));
        chk("rst_rq_beat", 64'(rq_beat), 64'(0));
        chk("rst_rq_done", 64'(rq_done), 64'(0));
        chk("rst_rq_resp", 64'(rq_resp), 64'(0));
        chk("rst_m_id", 64'(mif.m_id), 64'(0));
        chk("rst_m_addr", 64'(mif.m_addr), 64'(0));
        chk("rst_m_len", 64'(mif.m_len), 64'(0));
        chk("rst_m_size", 64'(mif.m_size), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Requester 0 burst of four back-to-back beats.
        rq0_addr = 32'h8000_0010; rq0_len = 8'd3; rq0_size = 2'b11;
        rq_valid = 2'b01;
        mif.m_ready = 1'b1;
        expect_txn(1'b0, 32'h8000_0010, 8'd3, 2'b11, 2'b00);
        #1;
        chk("lat_m_valid_idle", 64'(mif.m_valid), 64'(0));
        step();
        chk("lat_m_valid_issue", 64'(mif.m_valid), 64'(1));
        chk("busy_issue", 64'(busy), 64'(1));
        serve(4, 1'b0, 1'b0, 1'b1, 2'b00);
        chk("busy_after_t1", 64'(busy), 64'(0));

        // Contention from a fresh reset, single-beat transactions.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        rq0_addr = 32'h8000_0100; rq0_len = 8'd0; rq0_size = 2'b11;
        rq1_addr = 32'h1000_0008; rq1_len = 8'd5; rq1_size = 2'b10;
        rq_valid = 2'b11;
`ifdef YSYX_22041071_AXI_W_ARB_FIXED_PRIO_EN
        expect_txn(1'b1, 32'h1000_0008, 8'd0, 2'b10, 2'b01);
        expect_txn(1'b1, 32'h1000_0008, 8'd0, 2'b10, 2'b10);
        expect_txn(1'b1, 32'h1000_0008, 8'd0, 2'b10, 2'b11);
`else
        expect_txn(1'b0, 32'h8000_0100, 8'd0, 2'b11, 2'b01);
        expect_txn(1'b1, 32'h1000_0008, 8'd0, 2'b10, 2'b10);
        expect_txn(1'b0, 32'h8000_0100, 8'd0, 2'b11, 2'b11);
`endif
        serve(1, 1'b0, 1'b0, 1'b0, 2'b01);
        serve(1, 1'b0, 1'b0, 1'b0, 2'b10);
        serve(1, 1'b0, 1'b0, 1'b0, 2'b11);
        rq_valid = 2'b00;
        chk("busy_after_t2", 64'(busy), 64'(0));
`ifdef YSYX_22041071_AXI_W_ARB_FIXED_PRIO_EN
        chk("resp_hold0", 64'(rq_resp[0]), 64'(0));
        chk("resp_hold1", 64'(rq_resp[1]), 64'(3));
`else
        chk("resp_hold0", 64'(rq_resp[0]), 64'(3));
        chk("resp_hold1", 64'(rq_resp[1]), 64'(2));
`endif

        // MMIO store with the master stalling for five cycles.
        rq1_addr = 32'h1000_0040; rq1_len = 8'd3; rq1_size = 2'b01;
        rq_valid = 2'b10;
        mif.m_ready = 1'b0;
        expect_txn(1'b1, 32'h1000_0040, 8'd0, 2'b01, 2'b10);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_m_valid", 64'(mif.m_valid), 64'(1));
            chk("stall_m_addr", 64'(mif.m_addr), 64'(32'h1000_0040));
            chk("stall_m_len", 64'(mif.m_len), 64'(0));
            chk("stall_m_size", 64'(mif.m_size), 64'(1));
            step();
            rq1_addr = 32'hDEAD_BEEC;
            rq1_size = 2'b11;
        end
        serve(1, 1'b0, 1'b0, 1'b1, 2'b10);
        chk("busy_after_t3", 64'(busy), 64'(0));

        // Eight-beat burst with gapped W handshakes and a stray beat in RESP.
        rq0_addr = 32'h8000_0200; rq0_len = 8'd7; rq0_size = 2'b11;
        rq_valid = 2'b01;
        expect_txn(1'b0, 32'h8000_0200, 8'd7, 2'b11, 2'b10);
        serve(8, 1'b1, 1'b1, 1'b1, 2'b10);
        chk("busy_after_t4", 64'(busy), 64'(0));
        chk("resp_t4", 64'(rq_resp[0]), 64'(2));

        // Reset in the middle of a burst after two beats.
        rq0_addr = 32'h8000_0300; rq0_len = 8'd7;
        rq_valid = 2'b01;
        expect_txn(1'b0, 32'h8000_0300, 8'd7, 2'b11, 2'b01);
        mif.m_ready = 1'b1;
        acc_seen = 1'b0;
        step();
        step();
        chk("t5_accept", 64'(acc_seen), 64'(1));
        mif.m_ready = 1'b0;
        rq_valid = 2'b00;
        start = nbeats;
        mif.m_beat = 1'b1;
        step();
        step();
        chk("t5_beats", 64'(nbeats - start), 64'(2));
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_m_valid", 64'(mif.m_valid), 64'(0));
        chk("mid_rst_rq_beat", 64'(rq_beat), 64'(0));
        chk("mid_rst_rq_done", 64'(rq_done), 64'(0));
        chk("mid_rst_rq_resp", 64'(rq_resp), 64'(0));
        chk("mid_rst_m_addr", 64'(mif.m_addr), 64'(0));
        chk("mid_rst_m_id", 64'(mif.m_id), 64'(0));
        chk("mid_rst_m_len", 64'(mif.m_len), 64'(0));
        chk("mid_rst_m_data", mif.m_data, 64'(0));
        mif.m_beat = 1'b0;
        beat_q.delete();
        done_q.delete();
        exp0 = idx0;
        step();
        chk("mid_rst_no_done", 64'(rq_done), 64'(0));
        reset = 1'b0;

        rq0_addr = 32'h8000_0400; rq0_len = 8'd0; rq0_size = 2'b10;
        rq1_addr = 32'h1000_0080; rq1_size = 2'b11;
        rq_valid = 2'b11;
`ifdef YSYX_22041071_AXI_W_ARB_FIXED_PRIO_EN
        expect_txn(1'b1, 32'h1000_0080, 8'd0, 2'b11, 2'b01);
`else
        expect_txn(1'b0, 32'h8000_0400, 8'd0, 2'b10, 2'b01);
`endif
        serve(1, 1'b0, 1'b0, 1'b1, 2'b01);
        step();
        chk("busy_final", 64'(busy), 64'(0));
        chk("req_q_drained", 64'(req_q.size()), 64'(0));
        chk("beat_q_drained", 64'(beat_q.size()), 64'(0));
        chk("done_q_drained", 64'(done_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
